// File: rtl/ipu_frame_ctrl.sv
// Frame-level sequencer for the IPU: arms it, gates one camera frame (SOF..EOF) into it,
// then publishes the detected (X,Y) through a valid/ack register with timeout and abort.
module ipu_frame_ctrl #(
  parameter int          H_ACTIVE       = 640,
  parameter int          V_ACTIVE       = 480,
  parameter int          RES_TIMEOUT    = 1024,
  // Reset value of the published-result counter; lets a system start numbering from a chosen point.
  parameter logic [15:0] FRAME_CNT_INIT = 16'd0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iStart,
  input  logic        iContinuous,
  input  logic        iAbort,
  output logic        oIPU_DVAL,
  output logic        oIPU_RST,
  input  logic [10:0] iIPU_X,
  input  logic [10:0] iIPU_Y,
  input  logic        iIPU_DVAL,
  output logic [10:0] oX,
  output logic [10:0] oY,
  output logic        oValid,
  input  logic        iAck,
  output logic        oBusy,
  output logic        oTimeout,
  output logic [15:0] oFrameCnt
);

  localparam int               TW       = $clog2(RES_TIMEOUT + 1);
  localparam logic [10:0]      EOF_X    = 11'(H_ACTIVE - 1);
  localparam logic [10:0]      EOF_Y    = 11'(V_ACTIVE - 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(RES_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_SOF,
    ACTIVE,
    WAIT_RES,
    HOLD
  } state_t;

  state_t        state;
  logic [TW-1:0] tmoCnt;
  logic          sof;
  logic          eof;

  assign sof = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
  assign eof = iDVAL && (iX_Cont == EOF_X) && (iY_Cont == EOF_Y);

  // The IPU reset follows the system reset and is also pulsed for the single ARM cycle.
  assign oIPU_RST  = iRST && (state != ARM);
  assign oIPU_DVAL = iDVAL && ((state == WAIT_SOF && sof) || state == ACTIVE) && !iAbort;
  assign oBusy     = (state != IDLE);

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state     <= IDLE;
      oX        <= '0;
      oY        <= '0;
      oValid    <= 1'b0;
      oTimeout  <= 1'b0;
      oFrameCnt <= FRAME_CNT_INIT;
      tmoCnt    <= '0;
    end else begin
      oTimeout <= 1'b0;
      if (iAbort) begin
        state  <= IDLE;
        oValid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iStart || iContinuous) state <= ARM;
          end
          ARM: begin
            state <= WAIT_SOF;
          end
          WAIT_SOF: begin
            if (sof) state <= ACTIVE;
          end
          ACTIVE: begin
            if (eof) begin
              state  <= WAIT_RES;
              tmoCnt <= '0;
            end
          end
          WAIT_RES: begin
            // A result arriving on the last allowed cycle still beats the timeout.
            if (iIPU_DVAL) begin
              oX        <= iIPU_X;
              oY        <= iIPU_Y;
              oValid    <= 1'b1;
              oFrameCnt <= oFrameCnt + 16'd1;
              state     <= HOLD;
            end else if (tmoCnt == TMO_LAST) begin
              oTimeout <= 1'b1;
              state    <= iContinuous ? ARM : IDLE;
            end else begin
              tmoCnt <= tmoCnt + 1'b1;
            end
          end
          HOLD: begin
            if (iAck) begin
              oValid <= 1'b0;
              state  <= iContinuous ? ARM : IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipu_frame_ctrl.sv
// Randomized frame-transaction bench for ipu_frame_ctrl; expectations come from the
// transaction rules (pixel window, result wait, ack/abort/timeout), not from the RTL.
module tb_ipu_frame_ctrl;

  localparam int          H         = 8;
  localparam int          V         = 4;
  localparam int          TMO       = 16;
  localparam logic [15:0] WRAP_INIT = 16'hFFFF;

  localparam int K_NORM    = 0;
  localparam int K_TMO     = 1;
  localparam int K_AB_ACT  = 2;
  localparam int K_AB_RES  = 3;
  localparam int K_AB_HOLD = 4;

  logic        iCLK, iRST, iDVAL, iStart, iContinuous, iAbort, iIPU_DVAL, iAck;
  logic [10:0] iX_Cont, iY_Cont, iIPU_X, iIPU_Y;
  logic        oIPU_DVAL, oIPU_RST, oValid, oBusy, oTimeout;
  logic [10:0] oX, oY;
  logic [15:0] oFrameCnt;
  logic        wIpuDval, wIpuRst, wValid, wBusy, wTimeout;
  logic [10:0] wX, wY;
  logic [15:0] wFrameCnt;

  int vecCnt = 0;
  int errCnt = 0;
  int txnNum = 0;
  int fwdCnt = 0;
  int expCnt = 0;
  int expX   = 0;
  int expY   = 0;
  bit atArm  = 0;

  ipu_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .RES_TIMEOUT(TMO)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iStart(iStart), .iContinuous(iContinuous), .iAbort(iAbort),
    .oIPU_DVAL(oIPU_DVAL), .oIPU_RST(oIPU_RST),
    .iIPU_X(iIPU_X), .iIPU_Y(iIPU_Y), .iIPU_DVAL(iIPU_DVAL),
    .oX(oX), .oY(oY), .oValid(oValid), .iAck(iAck),
    .oBusy(oBusy), .oTimeout(oTimeout), .oFrameCnt(oFrameCnt)
  );

  // Same stimulus, counter seeded one below the wrap point.
  ipu_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .RES_TIMEOUT(TMO), .FRAME_CNT_INIT(WRAP_INIT)) dutWrap (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iStart(iStart), .iContinuous(iContinuous), .iAbort(iAbort),
    .oIPU_DVAL(wIpuDval), .oIPU_RST(wIpuRst),
    .iIPU_X(iIPU_X), .iIPU_Y(iIPU_Y), .iIPU_DVAL(iIPU_DVAL),
    .oX(wX), .oY(wY), .oValid(wValid), .iAck(iAck),
    .oBusy(wBusy), .oTimeout(wTimeout), .oFrameCnt(wFrameCnt)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checkpoint one time unit after the falling edge: inputs are driven here, outputs sampled.
  task automatic adv();
    @(negedge iCLK);
    #1;
  endtask

  task automatic drivePix(input logic dv, input int x, input int y, input logic abort, input logic expFwd);
    iDVAL   = dv;
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    iAbort  = abort;
    #1;
    chk("ipu_dval", {31'd0, oIPU_DVAL}, {31'd0, expFwd});
    if (oIPU_DVAL) fwdCnt++;
    adv();
    iAbort = 1'b0;
    iDVAL  = 1'b0;
  endtask

  // One raster frame with random idle gaps; stops right after an abort pixel if requested.
  task automatic streamFrame(input logic expFwd, input int abortAt);
    for (int p = 0; p < H * V; p++) begin
      while ($urandom_range(0, 3) == 0)
        drivePix(1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 1'b0, 1'b0);
      drivePix(1'b1, p % H, p / H, 1'(p == abortAt), expFwd && (p != abortAt));
      if (p == abortAt) return;
    end
  endtask

  task automatic doTxn(input int kind, input bit cont, input int k, input int abortAt,
                       input bit frame2, input int resX, input int resY);
    int rx;
    int ry;
    int n;
    txnNum++;
    $display("txn %0d: kind=%0d cont=%0d wait=%0d abortAt=%0d frame2=%0d published=%0d",
             txnNum, kind, cont, k, abortAt, frame2, expCnt);
    iContinuous = cont;
    if (!atArm) begin
      chk("idle_busy", {31'd0, oBusy}, 0);
      iStart = 1'b1;
      adv();
      iStart = 1'b0;
      chk("arm_tmo_clear", {31'd0, oTimeout}, 0);
    end
    chk("arm_ipu_rst", {31'd0, oIPU_RST}, 0);
    chk("arm_busy", {31'd0, oBusy}, 1);
    adv();
    chk("sof_ipu_rst", {31'd0, oIPU_RST}, 1);
    chk("sof_tmo", {31'd0, oTimeout}, 0);
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++)
      drivePix(1'b1, $urandom_range(1, H - 1), $urandom_range(0, V - 1), 1'b0, 1'b0);

    fwdCnt = 0;
    streamFrame(1'b1, (kind == K_AB_ACT) ? abortAt : -1);
    if (kind == K_AB_ACT) begin
      chk("abort_fwd", fwdCnt, abortAt);
      chk("abort_busy", {31'd0, oBusy}, 0);
      chk("abort_valid", {31'd0, oValid}, 0);
      chk("abort_cnt", {16'd0, oFrameCnt}, {16'd0, 16'(expCnt)});
      atArm = 0;
      return;
    end
    chk("frame_fwd", fwdCnt, H * V);

    n = (kind == K_TMO) ? TMO : k;
    for (int i = 0; i < n; i++) begin
      iAck = 1'($urandom_range(0, 1));
      chk("res_tmo_low", {31'd0, oTimeout}, 0);
      chk("res_valid_low", {31'd0, oValid}, 0);
      adv();
    end
    iAck = 1'b0;
    if (kind == K_TMO) begin
      chk("tmo_pulse", {31'd0, oTimeout}, 1);
      chk("tmo_valid", {31'd0, oValid}, 0);
      chk("tmo_x", {21'd0, oX}, expX);
      chk("tmo_cnt", {16'd0, oFrameCnt}, {16'd0, 16'(expCnt)});
      chk("tmo_busy", {31'd0, oBusy}, {31'd0, cont});
      atArm = cont;
      if (!cont) begin
        adv();
        chk("tmo_one_cycle", {31'd0, oTimeout}, 0);
      end
      return;
    end

    rx = (resX < 0) ? int'($urandom_range(0, 2047)) : resX;
    ry = (resY < 0) ? int'($urandom_range(0, 2047)) : resY;
    iIPU_X    = 11'(rx);
    iIPU_Y    = 11'(ry);
    iIPU_DVAL = 1'b1;
    iAbort    = (kind == K_AB_RES);
    adv();
    iIPU_DVAL = 1'b0;
    iAbort    = 1'b0;
    if (kind == K_AB_RES) begin
      chk("abres_valid", {31'd0, oValid}, 0);
      chk("abres_x", {21'd0, oX}, expX);
      chk("abres_cnt", {16'd0, oFrameCnt}, {16'd0, 16'(expCnt)});
      chk("abres_busy", {31'd0, oBusy}, 0);
      atArm = 0;
      return;
    end
    expCnt++;
    expX = rx;
    expY = ry;
    chk("pub_valid", {31'd0, oValid}, 1);
    chk("pub_x", {21'd0, oX}, expX);
    chk("pub_y", {21'd0, oY}, expY);
    chk("pub_cnt", {16'd0, oFrameCnt}, {16'd0, 16'(expCnt)});
    chk("pub_wrap_cnt", {16'd0, wFrameCnt}, {16'd0, 16'(WRAP_INIT + expCnt)});
    chk("pub_busy", {31'd0, oBusy}, 1);
    chk("pub_tmo", {31'd0, oTimeout}, 0);

    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      iIPU_DVAL = 1'($urandom_range(0, 1));
      iIPU_X    = 11'($urandom_range(0, 2047));
      iIPU_Y    = 11'($urandom_range(0, 2047));
      chk("hold_valid", {31'd0, oValid}, 1);
      chk("hold_x", {21'd0, oX}, expX);
      chk("hold_y", {21'd0, oY}, expY);
      drivePix(1'b1, (i == 0) ? 0 : $urandom_range(0, H - 1), (i == 0) ? 0 : $urandom_range(0, V - 1),
               1'b0, 1'b0);
    end
    iIPU_DVAL = 1'b0;
    if (frame2) begin
      fwdCnt = 0;
      streamFrame(1'b0, -1);
      chk("hold_frame_fwd", fwdCnt, 0);
      chk("hold_valid2", {31'd0, oValid}, 1);
    end
    iAck   = 1'b1;
    iAbort = (kind == K_AB_HOLD);
    adv();
    iAck   = 1'b0;
    iAbort = 1'b0;
    chk("ack_valid", {31'd0, oValid}, 0);
    chk("ack_x", {21'd0, oX}, expX);
    chk("ack_y", {21'd0, oY}, expY);
    chk("ack_cnt", {16'd0, oFrameCnt}, {16'd0, 16'(expCnt)});
    if (kind == K_AB_HOLD) begin
      chk("abhold_busy", {31'd0, oBusy}, 0);
      atArm = 0;
    end else begin
      chk("ack_busy", {31'd0, oBusy}, {31'd0, cont});
      chk("ack_ipu_rst", {31'd0, oIPU_RST}, {31'd0, !cont});
      atArm = cont;
    end
  endtask

  initial begin
    int kind;
    iRST = 1'b0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0; iStart = 1'b1;
    iContinuous = 1'b0; iAbort = 1'b0; iIPU_X = '0; iIPU_Y = '0; iIPU_DVAL = 1'b0; iAck = 1'b0;

    adv();
    chk("rst_valid", {31'd0, oValid}, 0);
    chk("rst_cnt", {16'd0, oFrameCnt}, 0);
    chk("rst_ipu_rst", {31'd0, oIPU_RST}, 0);
    chk("rst_busy", {31'd0, oBusy}, 0);
    chk("rst_tmo", {31'd0, oTimeout}, 0);
    chk("rst_x", {21'd0, oX}, 0);
    chk("rst_wrap_cnt", {16'd0, wFrameCnt}, {16'd0, WRAP_INIT});
    adv();
    chk("rst2_busy", {31'd0, oBusy}, 0);
    chk("rst2_ipu_rst", {31'd0, oIPU_RST}, 0);
    iStart = 1'b0;
    iRST   = 1'b1;
    #1;
    chk("rel_ipu_rst", {31'd0, oIPU_RST}, 1);

    doTxn(K_NORM, 0, 3, -1, 1, 5, 2);
    repeat (3) doTxn(K_NORM, 1, $urandom_range(0, 15), -1, 0, -1, -1);
    doTxn(K_TMO, 0, 0, -1, 0, -1, -1);
    doTxn(K_TMO, 1, 0, -1, 0, -1, -1);
    doTxn(K_NORM, 0, TMO - 1, -1, 0, -1, -1);
    doTxn(K_AB_ACT, 0, 0, 1 * H + 3, 0, -1, -1);
    doTxn(K_AB_HOLD, 0, 2, -1, 0, -1, -1);
    doTxn(K_AB_RES, 1, 4, -1, 0, -1, -1);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 7);
      if (kind > K_AB_HOLD) kind = K_NORM;
      doTxn(kind, 1'($urandom_range(0, 1)), $urandom_range(0, TMO - 1), $urandom_range(0, H * V - 1),
            1'($urandom_range(0, 3) == 0), -1, -1);
    end

    iRST = 1'b0;
    adv();
    chk("rerst_cnt", {16'd0, oFrameCnt}, 0);
    chk("rerst_valid", {31'd0, oValid}, 0);
    chk("rerst_busy", {31'd0, oBusy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
